// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - pattern modes, register map and reset values for pattern_engine
package pattern_pkg;

  typedef enum logic [2:0] {
    MODE_PASS       = 3'd0,
    MODE_RAMP       = 3'd1,
    MODE_BARS       = 3'd2,
    MODE_XOR_STATIC = 3'd3,
    MODE_XOR_ANIM   = 3'd4,
    MODE_SOLID      = 3'd5,
    MODE_CHECKER    = 3'd6,
    MODE_OFF        = 3'd7
  } mode_e;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_VOFFSET = 3'd1;
  localparam logic [2:0] ADDR_SCROLL  = 3'd2;
  localparam logic [2:0] ADDR_SOLID_R = 3'd3;
  localparam logic [2:0] ADDR_SOLID_G = 3'd4;
  localparam logic [2:0] ADDR_SOLID_B = 3'd5;

  typedef struct packed {
    logic [7:0] ctrl;
    logic [7:0] voffset;
    logic [7:0] scroll;
    logic [7:0] solid_r;
    logic [7:0] solid_g;
    logic [7:0] solid_b;
  } cfg_t;

  localparam logic [7:0] CTRL_DEFAULT    = 8'h00;
  localparam logic [7:0] VOFFSET_DEFAULT = 8'h00;
  localparam logic [7:0] SCROLL_DEFAULT  = 8'h00;
  localparam logic [7:0] SOLID_DEFAULT   = 8'h00;

  localparam cfg_t CFG_DEFAULT = '{
    ctrl:    CTRL_DEFAULT,
    voffset: VOFFSET_DEFAULT,
    scroll:  SCROLL_DEFAULT,
    solid_r: SOLID_DEFAULT,
    solid_g: SOLID_DEFAULT,
    solid_b: SOLID_DEFAULT
  };

endpackage

// File: rtl/pattern_xor.sv
// rtl/pattern_xor.sv - combinational XOR pattern, optionally animated by the frame counter
module pattern_xor #(
  parameter int COLOR_BITS = 8,
  parameter int POS_BITS   = 10,
  parameter int T_BITS     = 12
) (
  input  logic [POS_BITS-1:0]   hpos,
  input  logic [POS_BITS-1:0]   vv,
  input  logic [T_BITS-1:0]     frame_count,
  input  logic                  anim,
  output logic [COLOR_BITS-1:0] xr,
  output logic [COLOR_BITS-1:0] xg,
  output logic [COLOR_BITS-1:0] xb
);
  // Headroom so the animated sums keep their carry before the right shift.
  localparam int XW = ((POS_BITS > T_BITS) ? POS_BITS : T_BITS) + 2;

  logic [XW-1:0] h, v, fr, fg, fb;

  assign h  = XW'(hpos);
  assign v  = XW'(vv);
  assign fr = anim ? XW'(frame_count >> 3) : '0;
  assign fg = anim ? XW'(frame_count >> 2) : '0;
  assign fb = anim ? XW'(frame_count >> 1) : '0;

  assign xr = COLOR_BITS'(((h + fr) >> 1) ^ ((v + fr) >> 1));
  assign xg = COLOR_BITS'((h + fg) ^ (v + fg));
  assign xb = COLOR_BITS'(((h + fb) << 1) ^ ((v + fb) << 1));

endmodule

// File: rtl/pattern_engine.sv
// rtl/pattern_engine.sv - test-pattern generator with frame-synchronous config commit
module pattern_engine
  import pattern_pkg::*;
#(
  parameter int   COLOR_BITS = 8,
  parameter int   POS_BITS   = 10,
  parameter int   T_BITS     = 12,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [POS_BITS-1:0]   hpos,
  input  logic [POS_BITS-1:0]   vpos,
  input  logic                  visible,
  input  logic                  hblank,
  input  logic                  vblank,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  frame_end,
  input  logic [COLOR_BITS-1:0] pass_in,
  input  logic                  cfg_valid,
  input  logic [2:0]            cfg_addr,
  input  logic [7:0]            cfg_data,
  output logic                  cfg_ready,
  output logic                  cfg_pending,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  hblank_out,
  output logic                  vblank_out,
  output logic [T_BITS-1:0]     frame_count
);
  typedef logic [COLOR_BITS-1:0] pix_t;

  // Stage flag order: {visible, hsync, vsync, hblank, vblank}
  localparam logic [4:0] FLG1_RST = {1'b0, SYNC_IDLE, SYNC_IDLE, 2'b00};
  localparam logic [3:0] FLG2_RST = {SYNC_IDLE, SYNC_IDLE, 2'b00};

  cfg_t              shadow_q, shadow_d, active_q, active_d;
  logic              voff_wr_q, voff_wr_d, pending_q, pending_d;
  logic [T_BITS-1:0] fcnt_q, fcnt_d;

  assign cfg_ready = !reset && !frame_end;

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    voff_wr_d = voff_wr_q;
    pending_d = pending_q;
    fcnt_d    = fcnt_q;
    if (cfg_valid && cfg_ready) begin
      case (cfg_addr)
        ADDR_CTRL:    shadow_d.ctrl = cfg_data;
        ADDR_VOFFSET: begin
          shadow_d.voffset = cfg_data;
          voff_wr_d        = 1'b1;
        end
        ADDR_SCROLL:  shadow_d.scroll  = cfg_data;
        ADDR_SOLID_R: shadow_d.solid_r = cfg_data;
        ADDR_SOLID_G: shadow_d.solid_g = cfg_data;
        ADDR_SOLID_B: shadow_d.solid_b = cfg_data;
        default: ;
      endcase
      if (cfg_addr <= ADDR_SOLID_B) pending_d = 1'b1;
    end
    // An explicit VOFFSET write wins over this frame's scroll step.
    if (frame_end) begin
      active_d         = shadow_q;
      active_d.voffset = voff_wr_q ? shadow_q.voffset : active_q.voffset + shadow_q.scroll;
      voff_wr_d        = 1'b0;
      pending_d        = 1'b0;
      fcnt_d           = fcnt_q + T_BITS'(1);
    end
  end

  mode_e               mode;
  logic [1:0]          primary, divider;
  logic [POS_BITS-1:0] vv, hd;
  pix_t                ca, cb, cc, ramp_r, ramp_g, ramp_b, xr, xg, xb;
  pix_t                pat_r, pat_g, pat_b;
  logic                bar_inv, chk_on, unused_ctrl;

  assign mode        = mode_e'(active_q.ctrl[2:0]);
  assign primary     = active_q.ctrl[4:3];
  assign divider     = active_q.ctrl[6:5];
  assign unused_ctrl = active_q.ctrl[7];
  assign vv          = vpos + POS_BITS'(active_q.voffset);
  assign hd          = hpos >> divider;
  assign ca          = pix_t'(hd);
  assign cb          = pix_t'(vv);
  assign cc          = pix_t'(fcnt_q);
  assign bar_inv     = ((vpos >> 8) == '0) ? hd[0] : hpos[0];
  assign chk_on      = hpos[4] ^ vv[4];

  function automatic pix_t msb_align(input logic [7:0] v);
    logic [17:0] wide;
    wide = {v, 10'b0};
    return pix_t'(wide >> (18 - COLOR_BITS));
  endfunction

  pattern_xor #(
    .COLOR_BITS (COLOR_BITS),
    .POS_BITS   (POS_BITS),
    .T_BITS     (T_BITS)
  ) u_xor (
    .hpos        (hpos),
    .vv          (vv),
    .frame_count (fcnt_q),
    .anim        (mode == MODE_XOR_ANIM),
    .xr          (xr),
    .xg          (xg),
    .xb          (xb)
  );

  always_comb begin
    case (primary)
      2'd0:    {ramp_r, ramp_g, ramp_b} = {ca, cb, cc};
      2'd1:    {ramp_r, ramp_g, ramp_b} = {cc, ca, cb};
      2'd2:    {ramp_r, ramp_g, ramp_b} = {cb, cc, ca};
      default: {ramp_r, ramp_g, ramp_b} = {ca, ca, ca};
    endcase
  end

  always_comb begin
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    case (mode)
      MODE_PASS:       {pat_r, pat_g, pat_b} = {pass_in, pass_in, pass_in};
      MODE_RAMP:       {pat_r, pat_g, pat_b} = {ramp_r, ramp_g, ramp_b};
      MODE_BARS:       {pat_r, pat_g, pat_b} = {ramp_r, ramp_g, ramp_b} ^ {3*COLOR_BITS{bar_inv}};
      MODE_XOR_STATIC,
      MODE_XOR_ANIM:   {pat_r, pat_g, pat_b} = {xr, xg, xb};
      MODE_SOLID:      {pat_r, pat_g, pat_b} = {msb_align(active_q.solid_r),
                                                msb_align(active_q.solid_g),
                                                msb_align(active_q.solid_b)};
      MODE_CHECKER:    {pat_r, pat_g, pat_b} = {3*COLOR_BITS{chk_on}};
      default: ;
    endcase
  end

  pix_t       r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  pix_t       r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic [4:0] flg1_q, flg1_d;
  logic [3:0] flg2_q, flg2_d;

  always_comb begin
    r1_d   = pat_r;
    g1_d   = pat_g;
    b1_d   = pat_b;
    flg1_d = {visible, hsync_in, vsync_in, hblank, vblank};
    r2_d   = flg1_q[4] ? r1_q : '0;
    g2_d   = flg1_q[4] ? g1_q : '0;
    b2_d   = flg1_q[4] ? b1_q : '0;
    flg2_d = flg1_q[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q  <= CFG_DEFAULT;
      active_q  <= CFG_DEFAULT;
      voff_wr_q <= 1'b0;
      pending_q <= 1'b0;
      fcnt_q    <= '0;
      r1_q      <= '0;
      g1_q      <= '0;
      b1_q      <= '0;
      r2_q      <= '0;
      g2_q      <= '0;
      b2_q      <= '0;
      flg1_q    <= FLG1_RST;
      flg2_q    <= FLG2_RST;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      voff_wr_q <= voff_wr_d;
      pending_q <= pending_d;
      fcnt_q    <= fcnt_d;
      r1_q      <= r1_d;
      g1_q      <= g1_d;
      b1_q      <= b1_d;
      r2_q      <= r2_d;
      g2_q      <= g2_d;
      b2_q      <= b2_d;
      flg1_q    <= flg1_d;
      flg2_q    <= flg2_d;
    end
  end

  assign cfg_pending = pending_q;
  assign frame_count = fcnt_q;
  assign r           = r2_q;
  assign g           = g2_q;
  assign b           = b2_q;
  assign hsync_out   = flg2_q[3];
  assign vsync_out   = flg2_q[2];
  assign hblank_out  = flg2_q[1];
  assign vblank_out  = flg2_q[0];

endmodule
